// File: rtl/vga_fb_sequencer.sv
// vga_fb_sequencer: bus-addressed pixel writer and colour config for a VGA frame buffer.
// Register map from BASE_ADDR: +0 X, +1 Y, +2 pixel write, +3 fg colour,
// +4 bg colour, +5 fill start.
// Optional fill engine is built only when the macro VGA_FB_FILL_EN is defined.
module vga_fb_sequencer #(
  parameter logic [7:0]  BASE_ADDR = 8'hB0,
  parameter int unsigned H_PIXELS  = 160,
  parameter int unsigned V_PIXELS  = 120
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  input  logic [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic [15:0] CONFIG_COLOURS,
  output logic        BUSY
);

  localparam logic [7:0] ADDR_X   = BASE_ADDR;
  localparam logic [7:0] ADDR_Y   = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_PIX = BASE_ADDR + 8'd2;
  localparam logic [7:0] ADDR_FG  = BASE_ADDR + 8'd3;
  localparam logic [7:0] ADDR_BG  = BASE_ADDR + 8'd4;
  localparam logic [8:0] H_LIM    = 9'(H_PIXELS);
  localparam logic [7:0] V_LIM    = 8'(V_PIXELS);

  logic [7:0] x_reg;
  logic [6:0] y_reg;
  logic       wr;
  logic       cpu_req;
  logic       fill_issue;
  logic [7:0] fill_x;
  logic [6:0] fill_y;
  logic       fill_bit;

  // Bus writes are suppressed while reset is asserted.
  always_comb begin
    wr      = BUS_WE && !RESET;
    cpu_req = wr && (BUS_ADDR == ADDR_PIX) &&
              ({1'b0, x_reg} < H_LIM) && ({1'b0, y_reg} < V_LIM);
  end

  // Coordinate and colour configuration registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_reg          <= '0;
      y_reg          <= '0;
      CONFIG_COLOURS <= '0;
    end else if (wr) begin
      if (BUS_ADDR == ADDR_X) x_reg <= BUS_DATA;
      if (BUS_ADDR == ADDR_Y) y_reg <= BUS_DATA[6:0];
      if (BUS_ADDR == ADDR_FG) CONFIG_COLOURS[7:0]  <= BUS_DATA;
      if (BUS_ADDR == ADDR_BG) CONFIG_COLOURS[15:8] <= BUS_DATA;
    end
  end

`ifdef VGA_FB_FILL_EN
  localparam logic [7:0] ADDR_FILL = BASE_ADDR + 8'd5;
  localparam logic [7:0] FX_LAST   = 8'(H_PIXELS - 1);
  localparam logic [6:0] FY_LAST   = 7'(V_PIXELS - 1);

  typedef enum logic {IDLE, FILL} state_t;
  state_t     state, state_nxt;
  logic       start;
  logic       last;
  logic [7:0] fx;
  logic [6:0] fy;
  logic       fval;

  always_comb begin
    start = wr && (BUS_ADDR == ADDR_FILL);
    last  = (fx == FX_LAST) && (fy == FY_LAST);
  end

  // Fill state register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a start (re)enters FILL; the last issued pixel returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = FILL;
      FILL: begin
        if (start)                   state_nxt = FILL;
        else if (fill_issue && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill outputs: CPU pixel writes and (re)starts take the slot, fill holds.
  always_comb begin
    BUSY       = (state == FILL);
    fill_issue = (state == FILL) && !cpu_req && !start;
    fill_x     = fx;
    fill_y     = fy;
    fill_bit   = fval;
  end

  // Raster counters advance only on cycles where the fill owns the port.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fx   <= '0;
      fy   <= '0;
      fval <= 1'b0;
    end else if (start) begin
      fx   <= '0;
      fy   <= '0;
      fval <= BUS_DATA[0];
    end else if (fill_issue) begin
      if (fx == FX_LAST) begin
        fx <= '0;
        fy <= fy + 7'd1;
      end else begin
        fx <= fx + 8'd1;
      end
    end
  end
`else
  // No fill engine: BASE+5 decodes to nothing.
  always_comb begin
    BUSY       = 1'b0;
    fill_issue = 1'b0;
    fill_x     = '0;
    fill_y     = '0;
    fill_bit   = 1'b0;
  end
`endif

  // Registered frame-buffer port, one cycle behind the request.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      FB_WE   <= 1'b0;
      FB_ADDR <= '0;
      FB_DATA <= 1'b0;
    end else if (cpu_req) begin
      FB_WE   <= 1'b1;
      FB_ADDR <= {y_reg, x_reg};
      FB_DATA <= BUS_DATA[0];
    end else if (fill_issue) begin
      FB_WE   <= 1'b1;
      FB_ADDR <= {fill_y, fill_x};
      FB_DATA <= fill_bit;
    end else begin
      FB_WE   <= 1'b0;
    end
  end

endmodule

// File: doc/vga_fb_sequencer.md
VGA_FB_SEQUENCER -- requirements
Module: vga_fb_sequencer

Interface
- REQ-001 Parameter BASE_ADDR, default 8'hB0: first of six consecutive bus register addresses, BASE+0..BASE+5.
- REQ-002 Parameter H_PIXELS, default 160: frame-buffer width in pixels.
- REQ-003 Parameter V_PIXELS, default 120: frame-buffer height in pixels.
- REQ-004 CLK  input  1  single system clock; all logic on its rising edge.
- REQ-005 RESET  input  1  synchronous, active-high reset.
- REQ-006 BUS_ADDR  input  8  microprocessor bus address.
- REQ-007 BUS_DATA  input  8  microprocessor bus write data.
- REQ-008 BUS_WE  input  1  bus write strobe, one cycle per write.
- REQ-009 FB_ADDR  output  15  frame-buffer write address {Y[6:0], X[7:0]}.
- REQ-010 FB_DATA  output  1  frame-buffer write pixel value.
- REQ-011 FB_WE  output  1  frame-buffer write enable, one cycle per pixel.
- REQ-012 CONFIG_COLOURS  output  16  {background[7:0], foreground[7:0]} colour configuration for the VGA peripheral.
- REQ-013 BUSY  output  1  high while a fill sweep is in progress.

Function
- REQ-014 A write is a cycle with BUS_WE=1 and BUS_ADDR in BASE+0..BASE+5; other addresses are ignored.
- REQ-015 BASE+0 write latches X=BUS_DATA[7:0]; BASE+1 write latches Y=BUS_DATA[6:0].
- REQ-016 BASE+2 write requests a pixel write of BUS_DATA[0] at the current {Y,X}.
- REQ-017 BASE+3 write loads CONFIG_COLOURS[7:0]; BASE+4 write loads CONFIG_COLOURS[15:8]; both take effect the next cycle.
- REQ-018 BASE+5 write starts a fill sweep with fill value BUS_DATA[0].
- REQ-019 Pixel write latency: FB_WE=1, FB_ADDR={Y,X}, FB_DATA=value exactly one cycle after the BASE+2 write.
- REQ-020 A pixel write with X>=H_PIXELS or Y>=V_PIXELS is discarded; FB_WE stays 0.
- REQ-021 If BASE+0, BASE+1 and BASE+2 writes arrive on consecutive cycles, the pixel write uses the X/Y values latched before the BASE+2 cycle.
- REQ-022 Fill state machine has two states, IDLE and FILL.
- REQ-023 IDLE->FILL on a BASE+5 write; fill counters (fx, fy) reset to (0,0).
- REQ-024 FILL issues one write per granted cycle, in order fx=0..H_PIXELS-1 within each fy=0..V_PIXELS-1; it never generates X>=H_PIXELS.
- REQ-025 FILL->IDLE in the cycle after the write to (H_PIXELS-1, V_PIXELS-1) is issued; an unstalled fill takes H_PIXELS*V_PIXELS cycles (19200 at default parameters).
- REQ-026 Arbitration: a pending CPU pixel write has priority over the fill; that cycle the fill holds its counters and resumes next cycle without losing an address.
- REQ-027 A BASE+5 write during FILL restarts the sweep from (0,0) with the new fill value.
- REQ-028 BUSY=1 exactly while in FILL.
- REQ-029 FB_WE is never asserted for more than one source in the same cycle; FB_ADDR and FB_DATA are don't-care when FB_WE=0.

Reset
- REQ-030 While RESET=1: X=0, Y=0, CONFIG_COLOURS=16'h0000, FB_WE=0, FB_ADDR=0, FB_DATA=0, BUSY=0, state=IDLE, pending pixel write cleared.
- REQ-031 RESET asserted mid-fill aborts the sweep; no further FB_WE is issued after the reset cycle.
- REQ-032 A bus write in the same cycle as RESET=1 is ignored.

Configuration
- REQ-033 Macro VGA_FB_FILL_EN defined: the fill engine and BASE+5 behave per REQ-018, REQ-022 to REQ-028.
- REQ-034 VGA_FB_FILL_EN undefined: no fill logic is built, BASE+5 writes are ignored, BUSY is tied to 0, and pixel and colour writes are unchanged.

Verification
- REQ-035 Write B0<=8'h05, B1<=8'h03, B2<=8'h01 -> one cycle after the B2 write: FB_WE=1, FB_ADDR=15'h0305, FB_DATA=1; no other FB_WE pulse.
- REQ-036 Write B0<=8'hA0 (160), then B2<=8'h01 -> FB_WE stays 0.
- REQ-037 Write B3<=8'h1C, B4<=8'hE0 -> CONFIG_COLOURS=16'hE01C from the cycle after the B4 write.
- REQ-038 Write B5<=8'h01 -> BUSY rises next cycle; exactly 19200 FB_WE pulses with FB_DATA=1; last FB_ADDR=15'h779F; BUSY then falls.
- REQ-039 Mid-fill B2 write at (2,2) -> that cycle's write is {2,2} with the CPU value; the fill skips no address and the total is 19201 pulses.
- REQ-040 RESET pulse for one cycle mid-fill -> BUSY=0 and no FB_WE afterwards; CONFIG_COLOURS=0.
